// File: rtl/uart_i2c_bridge.sv
// uart_i2c_bridge: framed UART requests become I2C master burst writes or
// register reads; read data and a status byte go back on the UART TX stream.
module uart_i2c_bridge #(
    parameter int MAX_LEN        = 16,
    parameter int REG_BYTES      = 1,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter bit STATUS_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] m_tdata,
    input  logic       m_tvalid,
    output logic       m_tready,
    output logic [7:0] s_tdata,
    output logic       s_tvalid,
    input  logic       s_tready,
    output logic [6:0] s_cmd_addr,
    output logic       s_cmd_start,
    output logic       s_cmd_read,
    output logic       s_cmd_write,
    output logic       s_cmd_write_multiple,
    output logic       s_cmd_stop,
    output logic       s_cmd_valid,
    input  logic       s_cmd_ready,
    output logic [7:0] s_cmd_tdata,
    output logic       s_cmd_tvalid,
    output logic       s_cmd_tlast,
    input  logic       s_cmd_tready,
    input  logic [7:0] m_cmd_tdata,
    input  logic       m_cmd_tvalid,
    input  logic       m_cmd_tlast,
    output logic       m_cmd_tready,
    input  logic       missed_ack,
    output logic       busy
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, HDR, LEN, FILL, WCMD, WBURST, RCMD_REG,
        RREG, RCMD, RDATA, ABORT_STOP, DRAIN, STATUS
    } state_t;

    state_t        state, next;
    logic [6:0]    dev_addr;
    logic          rnw;
    logic [7:0]    reg_b [REG_BYTES];
    logic [7:0]    mem [MAX_LEN];
    logic [7:0]    len;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] buf_idx;
    logic [8:0]    idx;
    logic [TW-1:0] to_cnt;
    logic          nack, timeout, len_err;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [7:0]    reg_byte;
    logic [7:0]    status;
    logic          rx_fire, cmd_fire, wd_fire, rd_fire, fwd;
    logic          to_hit, wd_last, reg_last, byte_last, len_bad;
    logic          unused;

    assign unused    = &{1'b0, m_cmd_tlast};
    assign rx_fire   = m_tvalid && m_tready;
    assign cmd_fire  = s_cmd_valid && s_cmd_ready;
    assign wd_fire   = s_cmd_tvalid && s_cmd_tready;
    assign rd_fire   = m_cmd_tvalid && m_cmd_tready;
    assign fwd       = rd_valid && s_tready;
    assign to_hit    = to_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign reg_last  = idx == 9'(REG_BYTES - 1);
    assign byte_last = idx == {1'b0, len};
    assign wd_last   = idx == 9'(len) + 9'(REG_BYTES);
    assign len_bad   = m_tdata > 8'(MAX_LEN - 1);
    assign buf_idx   = AW'(idx - 9'(REG_BYTES));
    assign status    = {4'hA, 1'b0, len_err, timeout, nack};
    assign busy      = state != IDLE;

    always_comb begin
        reg_byte = 8'h00;
        for (int i = 0; i < REG_BYTES; i++)
            if (idx == 9'(i)) reg_byte = reg_b[i];
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:   if (rx_fire) next = HDR;
            HDR:    if (to_hit) next = STATUS;
                    else if (rx_fire && reg_last) next = LEN;
            LEN:    if (to_hit) next = STATUS;
                    else if (rx_fire) begin
                        if (len_bad)  next = DRAIN;
                        else if (rnw) next = RCMD_REG;
                        else          next = FILL;
                    end
            FILL:   if (to_hit) next = STATUS;
                    else if (rx_fire && byte_last) next = WCMD;
            WCMD:   if (cmd_fire) next = WBURST;
            WBURST: if (wd_fire && wd_last) next = STATUS;
            RCMD_REG: if (missed_ack) next = ABORT_STOP;
                      else if (cmd_fire) next = RREG;
            RREG:   if (missed_ack) next = ABORT_STOP;
                    else if (wd_fire && reg_last) next = RCMD;
            RCMD:   if (missed_ack) next = ABORT_STOP;
                    else if (cmd_fire) next = RDATA;
            RDATA:  if (missed_ack) next = ABORT_STOP;
                    else if (fwd) next = byte_last ? STATUS : RCMD;
            ABORT_STOP: if (cmd_fire) next = STATUS;
            DRAIN:  if (to_hit) next = STATUS;
            STATUS: if (!STATUS_EN || (s_tready && !rd_valid)) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        m_tready             = 1'b0;
        m_cmd_tready         = 1'b1;
        s_cmd_valid          = 1'b0;
        s_cmd_addr           = 7'h00;
        s_cmd_start          = 1'b0;
        s_cmd_read           = 1'b0;
        s_cmd_write          = 1'b0;
        s_cmd_write_multiple = 1'b0;
        s_cmd_stop           = 1'b0;
        s_cmd_tvalid         = 1'b0;
        s_cmd_tdata          = 8'h00;
        s_cmd_tlast          = 1'b0;
        s_tvalid             = rd_valid;
        s_tdata              = rd_valid ? rd_data : 8'h00;
        unique case (state)
            IDLE, HDR, LEN, FILL, DRAIN: m_tready = rstn;
            WCMD: begin
                s_cmd_valid          = 1'b1;
                s_cmd_addr           = dev_addr;
                s_cmd_write_multiple = 1'b1;
                s_cmd_start          = 1'b1;
                s_cmd_stop           = 1'b1;
            end
            WBURST: begin
                s_cmd_tvalid = 1'b1;
                s_cmd_tdata  = (idx < 9'(REG_BYTES)) ? reg_byte : mem[buf_idx];
                s_cmd_tlast  = wd_last;
            end
            RCMD_REG: begin
                s_cmd_valid          = 1'b1;
                s_cmd_addr           = dev_addr;
                s_cmd_write_multiple = 1'b1;
                s_cmd_start          = 1'b1;
            end
            RREG: begin
                s_cmd_tvalid = 1'b1;
                s_cmd_tdata  = reg_byte;
                s_cmd_tlast  = reg_last;
            end
            RCMD: begin
                s_cmd_valid = 1'b1;
                s_cmd_addr  = dev_addr;
                s_cmd_read  = 1'b1;
                s_cmd_start = idx == 9'd0;
                s_cmd_stop  = byte_last;
            end
            RDATA: m_cmd_tready = ~rd_valid;
            ABORT_STOP: begin
                s_cmd_valid = 1'b1;
                s_cmd_addr  = dev_addr;
                s_cmd_stop  = 1'b1;
            end
            STATUS: if (STATUS_EN && !rd_valid) begin
                s_tvalid = 1'b1;
                s_tdata  = status;
            end
            default: ;
        endcase
    end

    // Payload memory and register bytes carry no reset; they are always
    // rewritten by a frame before being read.
    always_ff @(posedge clk) begin
        if (state == FILL && rx_fire && !to_hit) mem[wr_ptr] <= m_tdata;
        for (int i = 0; i < REG_BYTES; i++)
            if (state == HDR && rx_fire && !to_hit && idx == 9'(i))
                reg_b[i] <= m_tdata;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dev_addr <= 7'h00;
            rnw      <= 1'b0;
            len      <= 8'h00;
            wr_ptr   <= '0;
            idx      <= 9'd0;
            to_cnt   <= '0;
            nack     <= 1'b0;
            timeout  <= 1'b0;
            len_err  <= 1'b0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            if (fwd) rd_valid <= 1'b0;
            if (rx_fire || !(state inside {HDR, LEN, FILL, DRAIN}))
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
            unique case (state)
                IDLE: if (rx_fire) begin
                    dev_addr <= m_tdata[7:1];
                    rnw      <= m_tdata[0];
                    nack     <= 1'b0;
                    timeout  <= 1'b0;
                    len_err  <= 1'b0;
                    idx      <= 9'd0;
                    wr_ptr   <= '0;
                end
                HDR: if (to_hit) timeout <= 1'b1;
                     else if (rx_fire) idx <= reg_last ? 9'd0 : idx + 9'd1;
                LEN: if (to_hit) timeout <= 1'b1;
                     else if (rx_fire) begin
                         len <= m_tdata;
                         idx <= 9'd0;
                         if (len_bad) len_err <= 1'b1;
                     end
                FILL: if (to_hit) timeout <= 1'b1;
                      else if (rx_fire) begin
                          wr_ptr <= wr_ptr + 1'b1;
                          idx    <= byte_last ? 9'd0 : idx + 9'd1;
                      end
                WCMD: begin
                    if (missed_ack) nack <= 1'b1;
                    if (cmd_fire) idx <= 9'd0;
                end
                WBURST: begin
                    if (missed_ack) nack <= 1'b1;
                    if (wd_fire) idx <= idx + 9'd1;
                end
                RCMD_REG: begin
                    if (missed_ack) nack <= 1'b1;
                    if (cmd_fire) idx <= 9'd0;
                end
                RREG: begin
                    if (missed_ack) nack <= 1'b1;
                    if (wd_fire) idx <= reg_last ? 9'd0 : idx + 9'd1;
                end
                RCMD: if (missed_ack) nack <= 1'b1;
                RDATA: begin
                    if (missed_ack) nack <= 1'b1;
                    if (rd_fire) begin
                        rd_data  <= m_cmd_tdata;
                        rd_valid <= 1'b1;
                    end
                    if (fwd) idx <= idx + 9'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_i2c_bridge.sv
// tb_uart_i2c_bridge: random framed requests checked against a
// transaction-level model of the bridge's I2C and UART traffic.
module tb_uart_i2c_bridge;
    localparam int MAX_LEN = 16;
    localparam int REG_BYTES = 1;
    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] m_tdata = 8'h00;
    logic       m_tvalid = 1'b0;
    logic       m_tready;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready = 1'b0;
    logic [6:0] s_cmd_addr;
    logic       s_cmd_start, s_cmd_read, s_cmd_write;
    logic       s_cmd_write_multiple, s_cmd_stop;
    logic       s_cmd_valid;
    logic       s_cmd_ready = 1'b0;
    logic [7:0] s_cmd_tdata;
    logic       s_cmd_tvalid, s_cmd_tlast;
    logic       s_cmd_tready = 1'b0;
    logic [7:0] m_cmd_tdata = 8'h00;
    logic       m_cmd_tvalid = 1'b0;
    logic       m_cmd_tlast = 1'b0;
    logic       m_cmd_tready;
    logic       missed_ack = 1'b0;
    logic       busy;

    uart_i2c_bridge #(
        .MAX_LEN(MAX_LEN), .REG_BYTES(REG_BYTES),
        .TIMEOUT_CYCLES(TO), .STATUS_EN(1'b1)
    ) dut (
        .clk(clk), .rstn(rstn),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_cmd_addr(s_cmd_addr), .s_cmd_start(s_cmd_start),
        .s_cmd_read(s_cmd_read), .s_cmd_write(s_cmd_write),
        .s_cmd_write_multiple(s_cmd_write_multiple),
        .s_cmd_stop(s_cmd_stop), .s_cmd_valid(s_cmd_valid),
        .s_cmd_ready(s_cmd_ready),
        .s_cmd_tdata(s_cmd_tdata), .s_cmd_tvalid(s_cmd_tvalid),
        .s_cmd_tlast(s_cmd_tlast), .s_cmd_tready(s_cmd_tready),
        .m_cmd_tdata(m_cmd_tdata), .m_cmd_tvalid(m_cmd_tvalid),
        .m_cmd_tlast(m_cmd_tlast), .m_cmd_tready(m_cmd_tready),
        .missed_ack(missed_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // command record: {addr, start, read, write, write_multiple, stop}
    function automatic logic [11:0] mk_cmd(input logic [6:0] a,
        input logic st, input logic rd, input logic wm, input logic sp);
        return {a, st, rd, 1'b0, wm, sp};
    endfunction

    logic [7:0]  rx_q[$], tx_got[$], exp_tx[$], rd_src[$], pay[$];
    logic [11:0] cmd_got[$], exp_cmd[$];
    logic [8:0]  wr_got[$], exp_wr[$];
    bit          rx_fire = 0, rd_fire = 0, nack_armed = 0, ack_pend = 0;
    int          rd_credit = 0;

    // UART endpoints and I2C master model; decisions made on the falling
    // edge take effect at the following rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_tvalid = 0; m_cmd_tvalid = 0; missed_ack = 0;
                rx_fire = 0; rd_fire = 0; ack_pend = 0;
                s_tready = 0; s_cmd_ready = 0; s_cmd_tready = 0;
            end else begin
                if (rx_fire) begin
                    if (rx_q.size() > 0) void'(rx_q.pop_front());
                    m_tvalid = 0;
                end
                if (!m_tvalid && rx_q.size() > 0 && $urandom_range(3) != 0) begin
                    m_tvalid = 1;
                    m_tdata = rx_q[0];
                end
                rx_fire = m_tvalid && m_tready;

                missed_ack = ack_pend;
                ack_pend = 0;
                if (rd_fire) m_cmd_tvalid = 0;
                if (!m_cmd_tvalid && rd_credit > 0 && rd_src.size() > 0
                    && $urandom_range(2) != 0) begin
                    m_cmd_tvalid = 1;
                    m_cmd_tlast = 1;
                    m_cmd_tdata = rd_src.pop_front();
                    rd_credit--;
                end
                rd_fire = m_cmd_tvalid && m_cmd_tready;

                s_cmd_ready = $urandom_range(3) != 0;
                if (s_cmd_valid && s_cmd_ready) begin
                    cmd_got.push_back({s_cmd_addr, s_cmd_start, s_cmd_read,
                        s_cmd_write, s_cmd_write_multiple, s_cmd_stop});
                    if (s_cmd_read) begin
                        if (nack_armed) begin
                            nack_armed = 0;
                            ack_pend = 1;
                        end else rd_credit++;
                    end
                end
                s_cmd_tready = $urandom_range(3) != 0;
                if (s_cmd_tvalid && s_cmd_tready)
                    wr_got.push_back({s_cmd_tlast, s_cmd_tdata});
                s_tready = $urandom_range(2) != 0;
                if (s_tvalid && s_tready) tx_got.push_back(s_tdata);
            end
        end
    end

    task automatic start_write(input logic [6:0] a, input logic [7:0] r);
        rx_q.push_back({a, 1'b0});
        rx_q.push_back(r);
        rx_q.push_back(8'(pay.size() - 1));
        foreach (pay[i]) rx_q.push_back(pay[i]);
        exp_cmd.push_back(mk_cmd(a, 1, 0, 1, 1));
        exp_wr.push_back({1'b0, r});
        foreach (pay[i]) exp_wr.push_back({i == pay.size() - 1, pay[i]});
        exp_tx.push_back(8'hA0);
    endtask

    task automatic start_read(input logic [6:0] a, input logic [7:0] r,
                              input int n, input bit nk);
        logic [7:0] b;
        rx_q.push_back({a, 1'b1});
        rx_q.push_back(r);
        rx_q.push_back(8'(n - 1));
        exp_cmd.push_back(mk_cmd(a, 1, 0, 1, 0));
        exp_wr.push_back({1'b1, r});
        if (nk) begin
            nack_armed = 1;
            exp_cmd.push_back(mk_cmd(a, 1, 1, 0, n == 1));
            exp_cmd.push_back(mk_cmd(a, 0, 0, 0, 1));
            exp_tx.push_back(8'hA1);
        end else begin
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                rd_src.push_back(b);
                exp_cmd.push_back(mk_cmd(a, i == 0, 1, 0, i == n - 1));
                exp_tx.push_back(b);
            end
            exp_tx.push_back(8'hA0);
        end
    endtask

    task automatic clear_all();
        rx_q.delete(); tx_got.delete(); exp_tx.delete(); rd_src.delete();
        cmd_got.delete(); exp_cmd.delete(); wr_got.delete(); exp_wr.delete();
        rd_credit = 0;
        nack_armed = 0;
    endtask

    task automatic finish_txn(input string tag, input int budget);
        for (int c = 0; c < budget && tx_got.size() < exp_tx.size(); c++)
            @(negedge clk);
        for (int c = 0; c < 50 && busy; c++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk({tag, ":busy"}, 32'(busy), 0);
        chk({tag, ":ntx"}, tx_got.size(), exp_tx.size());
        chk({tag, ":ncmd"}, cmd_got.size(), exp_cmd.size());
        chk({tag, ":nwr"}, wr_got.size(), exp_wr.size());
        foreach (exp_tx[i])
            if (i < tx_got.size()) chk({tag, ":tx"}, tx_got[i], exp_tx[i]);
        foreach (exp_cmd[i])
            if (i < cmd_got.size()) begin
                if (exp_cmd[i][4:0] == 5'b00001)
                    chk({tag, ":stopcmd"}, cmd_got[i][4:0], exp_cmd[i][4:0]);
                else
                    chk({tag, ":cmd"}, cmd_got[i], exp_cmd[i]);
            end
        foreach (exp_wr[i])
            if (i < wr_got.size()) chk({tag, ":wr"}, wr_got[i], exp_wr[i]);
        clear_all();
    endtask

    task automatic rand_pay(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        chk("rst:m_tready", 32'(m_tready), 0);
        chk("rst:s_tvalid", 32'(s_tvalid), 0);
        chk("rst:s_cmd_valid", 32'(s_cmd_valid), 0);
        chk("rst:s_cmd_tvalid", 32'(s_cmd_tvalid), 0);
        chk("rst:s_tdata", 32'(s_tdata), 0);
        chk("rst:m_cmd_tready", 32'(m_cmd_tready), 1);
        chk("rst:busy", 32'(busy), 0);
        rstn = 1;

        pay = '{8'h11, 8'h22, 8'h33};
        start_write(7'h4D, 8'h3B);
        finish_txn("write", 2000);

        start_read(7'h4D, 8'h03, 2, 0);
        rd_src = '{8'hC5, 8'h7E};
        exp_tx = '{8'hC5, 8'h7E, 8'hA0};
        finish_txn("read", 2000);

        rx_q = '{8'h9A, 8'h00, 8'h20, 8'h55, 8'hAA, 8'h01};
        exp_tx.push_back(8'hA4);
        finish_txn("lenerr", 4 * TO);

        rx_q = '{8'h9A, 8'h00, 8'h10};
        exp_tx.push_back(8'hA4);
        finish_txn("lenerr16", 4 * TO);

        rx_q = '{8'h9A, 8'h10};
        exp_tx.push_back(8'hA2);
        finish_txn("timeout", 4 * TO);

        rand_pay(MAX_LEN);
        start_write(7'h12, 8'hE7);
        finish_txn("write_max", 3000);

        start_read(7'h4D, 8'h03, 2, 1);
        finish_txn("nack", 2000);

        rand_pay(8);
        start_write(7'h2C, 8'h40);
        for (int c = 0; c < 1000 && wr_got.size() < 2; c++) @(negedge clk);
        chk("rst:in_burst", 32'(wr_got.size() >= 2), 1);
        @(negedge clk);
        #2 rstn = 0;
        @(negedge clk);
        #2 rstn = 1;
        clear_all();
        #1;
        chk("rst2:s_cmd_valid", 32'(s_cmd_valid), 0);
        chk("rst2:s_cmd_tvalid", 32'(s_cmd_tvalid), 0);
        chk("rst2:s_tvalid", 32'(s_tvalid), 0);
        chk("rst2:busy", 32'(busy), 0);
        rand_pay(5);
        start_write(7'h2C, 8'h41);
        finish_txn("after_rst", 2000);

        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(1) == 0) begin
                rand_pay($urandom_range(MAX_LEN, 1));
                start_write(7'($urandom), 8'($urandom));
                finish_txn("rnd_write", 3000);
            end else begin
                start_read(7'($urandom), 8'($urandom),
                           $urandom_range(MAX_LEN, 1), $urandom_range(5) == 0);
                finish_txn("rnd_read", 3000);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
